// File: rtl/sd_card_cmd.sv
// rtl/sd_card_cmd.sv - SD CMD line card-side responder; optional received-CRC check under SD_CMD_CRC_CHECK_EN
module sd_card_cmd #(
    parameter int NCR          = 2,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        icmd_sd,
    output logic        ocmd_sd,
    output logic        ocmd_oe,
    output logic        ocmd_valid,
    output logic [5:0]  ocmd_index,
    output logic [31:0] ocmd_arg,
    output logic        ocrc_fail,
    output logic        oframe_err,
    input  logic        iresp_valid,
    input  logic        iresp_none,
    input  logic        iresp_nocrc,
    input  logic [5:0]  iresp_index,
    input  logic [31:0] iresp_arg,
    output logic        obusy
);

    typedef enum logic [1:0] {IDLE, RECV, WAIT_RESP, SEND} state_t;

    localparam logic [7:0] NCR_W     = 8'(NCR);
    localparam logic [7:0] TIMEOUT_W = 8'(RESP_TIMEOUT);

    state_t      state, state_next;
    logic [5:0]  bit_cnt;
    logic [5:0]  bit_inc;
    logic [6:0]  gap_cnt;
    logic [7:0]  gap_inc;
    logic [38:0] rx_sr;          // transmission bit, index, arg
    logic [46:0] tx_sr;          // response bits still to be driven
    logic        pending;
    logic        resp_nocrc_q;
    logic [5:0]  resp_index_q;
    logic [31:0] resp_arg_q;
    logic        frame_bad;
    logic [47:0] resp_frame;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    function automatic logic [6:0] crc7_frame(input logic [39:0] d);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    // Counters saturate rather than wrap; gap_inc carries a spare bit for the compares
    assign bit_inc   = (bit_cnt == 6'h3F) ? bit_cnt : bit_cnt + 6'd1;
    assign gap_inc   = {1'b0, gap_cnt} + 8'd1;
    // At the end-bit edge the incoming bit is the end bit itself
    assign frame_bad = !rx_sr[38] || !icmd_sd;
    assign resp_frame = {2'b00, resp_index_q, resp_arg_q,
                         resp_nocrc_q ? 7'h7F : crc7_frame({2'b00, resp_index_q, resp_arg_q}),
                         1'b1};

`ifdef SD_CMD_CRC_CHECK_EN
    logic [6:0] rx_crc_calc;
    logic [6:0] rx_crc_field;
    logic       crc_bad;

    assign crc_bad = (rx_crc_calc != rx_crc_field);

    // Serial CRC7 over the first 40 received bits, capture of the sent CRC, mismatch pulse
    always_ff @(posedge iclk) begin
        if (irst) begin
            rx_crc_calc  <= 7'd0;
            rx_crc_field <= 7'd0;
            ocrc_fail    <= 1'b0;
        end else begin
            ocrc_fail <= 1'b0;
            if (state == IDLE) begin
                rx_crc_calc <= 7'd0;
            end else if (state == RECV) begin
                if (bit_cnt < 6'd40)
                    rx_crc_calc <= crc7_step(rx_crc_calc, icmd_sd);
                else if (bit_cnt < 6'd47)
                    rx_crc_field <= {rx_crc_field[5:0], icmd_sd};
                else
                    ocrc_fail <= !frame_bad && crc_bad;
            end
        end
    end
`else
    assign ocrc_fail = 1'b0;
`endif

    // State register
    always_ff @(posedge iclk) begin
        if (irst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state decode and busy flag
    always_comb begin
        state_next = state;
        obusy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (!icmd_sd) state_next = RECV;
            end
            RECV: begin
                if (bit_cnt == 6'd47) begin
                    if (frame_bad) state_next = IDLE;
`ifdef SD_CMD_CRC_CHECK_EN
                    else if (crc_bad) state_next = IDLE;
`endif
                    else state_next = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (iresp_valid && iresp_none)
                    state_next = IDLE;
                else if (pending && gap_inc >= NCR_W)
                    state_next = SEND;
                else if (!pending && !iresp_valid && gap_inc >= TIMEOUT_W)
                    state_next = IDLE;
            end
            SEND: begin
                if (bit_cnt == 6'd48) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Receive shifting, command latch, response latch and serializer
    always_ff @(posedge iclk) begin
        if (irst) begin
            ocmd_sd      <= 1'b1;
            ocmd_oe      <= 1'b0;
            ocmd_valid   <= 1'b0;
            oframe_err   <= 1'b0;
            ocmd_index   <= 6'd0;
            ocmd_arg     <= 32'd0;
            bit_cnt      <= 6'd0;
            gap_cnt      <= 7'd0;
            rx_sr        <= 39'd0;
            tx_sr        <= 47'd0;
            pending      <= 1'b0;
            resp_nocrc_q <= 1'b0;
            resp_index_q <= 6'd0;
            resp_arg_q   <= 32'd0;
        end else begin
            ocmd_valid <= 1'b0;
            oframe_err <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= 6'd1;
                    pending <= 1'b0;
                end
                RECV: begin
                    bit_cnt <= bit_inc;
                    if (bit_cnt < 6'd40) rx_sr <= {rx_sr[37:0], icmd_sd};
                    if (bit_cnt == 6'd47) begin
                        if (frame_bad) begin
                            oframe_err <= 1'b1;
                        end else if (state_next == WAIT_RESP) begin
                            ocmd_valid <= 1'b1;
                            ocmd_index <= rx_sr[37:32];
                            ocmd_arg   <= rx_sr[31:0];
                            gap_cnt    <= 7'd0;
                            pending    <= 1'b0;
                        end
                    end
                end
                WAIT_RESP: begin
                    gap_cnt <= (gap_cnt == 7'h7F) ? gap_cnt : gap_inc[6:0];
                    if (iresp_valid && !iresp_none) begin
                        resp_index_q <= iresp_index;
                        resp_arg_q   <= iresp_arg;
                        resp_nocrc_q <= iresp_nocrc;
                        pending      <= 1'b1;
                    end
                    if (state_next == SEND) begin
                        ocmd_sd <= resp_frame[47];
                        ocmd_oe <= 1'b1;
                        tx_sr   <= resp_frame[46:0];
                        bit_cnt <= 6'd1;
                        pending <= 1'b0;
                    end
                end
                SEND: begin
                    if (bit_cnt == 6'd48) begin
                        ocmd_oe <= 1'b0;
                        ocmd_sd <= 1'b1;
                    end else begin
                        ocmd_sd <= tx_sr[46];
                        tx_sr   <= {tx_sr[45:0], 1'b0};
                        bit_cnt <= bit_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_card_cmd.sv
// tb/tb_sd_card_cmd.sv - directed vector bench for sd_card_cmd
module tb_sd_card_cmd;

    logic        iclk = 1'b0;
    logic        irst;
    logic        icmd_sd;
    logic        ocmd_sd;
    logic        ocmd_oe;
    logic        ocmd_valid;
    logic [5:0]  ocmd_index;
    logic [31:0] ocmd_arg;
    logic        ocrc_fail;
    logic        oframe_err;
    logic        iresp_valid;
    logic        iresp_none;
    logic        iresp_nocrc;
    logic [5:0]  iresp_index;
    logic [31:0] iresp_arg;
    logic        obusy;

    int vectors = 0;
    int miscompares = 0;

    sd_card_cmd #(.NCR(2), .RESP_TIMEOUT(64)) dut (
        .iclk(iclk), .irst(irst), .icmd_sd(icmd_sd),
        .ocmd_sd(ocmd_sd), .ocmd_oe(ocmd_oe), .ocmd_valid(ocmd_valid),
        .ocmd_index(ocmd_index), .ocmd_arg(ocmd_arg), .ocrc_fail(ocrc_fail),
        .oframe_err(oframe_err), .iresp_valid(iresp_valid), .iresp_none(iresp_none),
        .iresp_nocrc(iresp_nocrc), .iresp_index(iresp_index), .iresp_arg(iresp_arg),
        .obusy(obusy)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic [47:0] frame;
        int          req_at;
        logic        none;
        logic        nocrc;
        logic [5:0]  rindex;
        logic [31:0] rarg;
        int          cycles;
        logic        exp_valid;
        logic        exp_crc;
        logic        exp_frame;
        logic [5:0]  exp_index;
        logic [31:0] exp_arg;
        int          exp_start;
        int          exp_idle;
    } vec_t;

    vec_t tv[9];

    // CRC7 as polynomial long division, remainder of d(x)*x^7 mod x^7+x^3+1
    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [46:0] w;
        w = {d, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (w[i]) w[i -: 8] = w[i -: 8] ^ 8'h89;
        return w[6:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            icmd_sd = f[i];
            step();
        end
        icmd_sd = 1'b1;
    endtask

    initial begin
        logic [47:0] cap;
        logic [47:0] exp_resp;
        int          first_oe;
        int          first_idle;
        int          oe_cnt;
        logic [5:0]  idx_after_crc;

        tv[0] = '{48'h40_0000_0000_95, 1, 1'b1, 1'b0, 6'h00, 32'h0, 2,
                  1'b1, 1'b0, 1'b0, 6'h00, 32'h0, -1, 1};
        tv[1] = '{48'h48_0000_01AA_87, 1, 1'b0, 1'b0, 6'h08, 32'h0000_01AA, 50,
                  1'b1, 1'b0, 1'b0, 6'h08, 32'h0000_01AA, 2, 50};
        tv[2] = '{48'h77_0000_0000_65, 10, 1'b0, 1'b0, 6'h37, 32'h0000_0120, 61,
                  1'b1, 1'b0, 1'b0, 6'h37, 32'h0, 11, 59};
`ifdef SD_CMD_CRC_CHECK_EN
        tv[3] = '{48'h40_0000_0000_97, 0, 1'b0, 1'b0, 6'h00, 32'h0, 66,
                  1'b0, 1'b1, 1'b0, 6'h37, 32'h0, -1, 0};
        idx_after_crc = 6'h37;
`else
        tv[3] = '{48'h40_0000_0000_97, 0, 1'b0, 1'b0, 6'h00, 32'h0, 66,
                  1'b1, 1'b0, 1'b0, 6'h00, 32'h0, -1, 64};
        idx_after_crc = 6'h00;
`endif
        tv[4] = '{48'h48_0000_01AA_86, 0, 1'b0, 1'b0, 6'h00, 32'h0, 1,
                  1'b0, 1'b0, 1'b1, idx_after_crc, 32'h0, -1, 0};
        tv[5] = '{48'h48_0000_01AA_87, 2, 1'b0, 1'b1, 6'h3F, 32'h80FF_8000, 51,
                  1'b1, 1'b0, 1'b0, 6'h08, 32'h0000_01AA, 3, 51};
        tv[6] = '{48'h00_1234_5678_FF, 0, 1'b0, 1'b0, 6'h00, 32'h0, 1,
                  1'b0, 1'b0, 1'b1, 6'h08, 32'h0000_01AA, -1, 0};
        tv[7] = '{48'h40_0000_0000_95, 0, 1'b0, 1'b0, 6'h00, 32'h0, 66,
                  1'b1, 1'b0, 1'b0, 6'h00, 32'h0, -1, 64};
        tv[8] = '{48'h77_0000_0000_65, 64, 1'b0, 1'b0, 6'h37, 32'hDEAD_BEEF, 115,
                  1'b1, 1'b0, 1'b0, 6'h37, 32'h0, 65, 113};

        irst = 1'b1; icmd_sd = 1'b1; iresp_valid = 1'b0; iresp_none = 1'b0;
        iresp_nocrc = 1'b0; iresp_index = 6'h0; iresp_arg = 32'h0;
        step(); step();
        chk("reset_outputs",
            {ocmd_sd, ocmd_oe, ocmd_valid, ocrc_fail, oframe_err, obusy, ocmd_index, ocmd_arg},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0});
        irst = 1'b0;
        step();

        for (int v = 0; v < 9; v++) begin
            send_frame(tv[v].frame);
            chk($sformatf("v%0d_valid", v), ocmd_valid, tv[v].exp_valid);
            chk($sformatf("v%0d_crc_fail", v), ocrc_fail, tv[v].exp_crc);
            chk($sformatf("v%0d_frame_err", v), oframe_err, tv[v].exp_frame);
            chk($sformatf("v%0d_index", v), ocmd_index, tv[v].exp_index);
            chk($sformatf("v%0d_arg", v), ocmd_arg, tv[v].exp_arg);
            first_oe = -1;
            first_idle = obusy ? -1 : 0;
            oe_cnt = 0;
            cap = 48'h0;
            for (int t = 1; t <= tv[v].cycles; t++) begin
                iresp_valid = (t == tv[v].req_at);
                iresp_none  = tv[v].none;
                iresp_nocrc = tv[v].nocrc;
                iresp_index = tv[v].rindex;
                iresp_arg   = tv[v].rarg;
                step();
                iresp_valid = 1'b0;
                if (t == 1)
                    chk($sformatf("v%0d_pulse_width", v), {ocmd_valid, ocrc_fail, oframe_err}, 3'b000);
                if (ocmd_oe) begin
                    if (first_oe < 0) first_oe = t;
                    oe_cnt++;
                    cap = {cap[46:0], ocmd_sd};
                end
                if (!obusy && first_idle < 0) first_idle = t;
            end
            chk($sformatf("v%0d_start_edge", v), first_oe, tv[v].exp_start);
            chk($sformatf("v%0d_oe_cycles", v), oe_cnt, (tv[v].exp_start >= 0) ? 48 : 0);
            chk($sformatf("v%0d_idle_edge", v), first_idle, tv[v].exp_idle);
            if (tv[v].exp_start >= 0) begin
                exp_resp = {2'b00, tv[v].rindex, tv[v].rarg,
                            tv[v].nocrc ? 7'h7F : crc7_ref({2'b00, tv[v].rindex, tv[v].rarg}),
                            1'b1};
                chk($sformatf("v%0d_resp_frame", v), cap, exp_resp);
            end
        end

        // Reset in the middle of a response releases the line at that edge
        send_frame(48'h48_0000_01AA_87);
        iresp_valid = 1'b1; iresp_none = 1'b0; iresp_nocrc = 1'b0;
        iresp_index = 6'h08; iresp_arg = 32'h1AA;
        step();
        iresp_valid = 1'b0;
        for (int t = 2; t <= 20; t++) step();
        chk("mid_send_oe_before_reset", ocmd_oe, 1'b1);
        irst = 1'b1;
        step();
        irst = 1'b0;
        chk("mid_send_reset",
            {ocmd_oe, ocmd_sd, obusy, ocmd_index, ocmd_arg},
            {1'b0, 1'b1, 1'b0, 6'h00, 32'h0});

        // Requests outside WAIT_RESP are ignored
        oe_cnt = 0;
        iresp_valid = 1'b1;
        for (int t = 0; t < 5; t++) begin
            step();
            if (ocmd_oe || obusy) oe_cnt++;
        end
        iresp_valid = 1'b0;
        chk("idle_request_ignored", oe_cnt, 0);

        // Receiver works normally after the reset
        send_frame(48'h77_0000_0000_65);
        chk("post_reset_valid", {ocmd_valid, ocmd_index}, {1'b1, 6'h37});
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
